imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the single-cycle core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially from word address 0 into the instruction memory write port, and holds the core in reset until the load finishes. It is the writer counterpart to the core's read-only instruction fetch path.

## Interface
- ADDR_WIDTH, 6, word-address width of the instruction memory; depth = 2^ADDR_WIDTH words.
- BOOT_HOLD, 1, reset value of cpu_rst; 1 = core held until first load completes, 0 = core runs from preloaded image.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- length  in  ADDR_WIDTH+1  number of words to load, sampled when start is honoured.
- in_valid  in  1  in_byte carries a valid byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts in_byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_waddr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  instruction word to write.
- cpu_rst  out  1  reset to the core, active high.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- word_count  out  ADDR_WIDTH+1  words written in the current or last load.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0, busy=0. On start: latch len = min(length, 2^ADDR_WIDTH), clear the byte index, address and word_count, and set cpu_rst=1.
  - If len=0, go to DONE; otherwise go to LOAD.
- LOAD: in_ready=1, busy=1. A byte is accepted when in_valid and in_ready are both 1.
  - Byte index k (0..3) goes to word[8k+7:8k]; the first byte is the LSB.
  - On accepting the byte with k=3, go to WRITE.
- WRITE (one cycle): in_ready=0, imem_we=1, imem_waddr=addr, imem_wdata=assembled word.
  - At the end of the cycle, addr and word_count each increment by 1.
  - If the new word_count equals len, go to DONE; otherwise return to LOAD with k=0.
- DONE (one cycle): done=1, busy=0, cpu_rst=0, then go to IDLE.
- cpu_rst stays 0 in IDLE after any completed load.
- start is ignored in LOAD, WRITE and DONE.
- in_valid is ignored outside LOAD, and a byte offered while in_ready=0 is not consumed.
- Address arithmetic is modulo 2^ADDR_WIDTH. The clamp on len means a load never wraps.
  - A full load of 64 words ends at address 63, and the internal address wraps to 0 only after the final write.
- imem_we is never asserted outside WRITE.
- Outside WRITE, imem_waddr and imem_wdata hold their last values.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from input to output.
- Reset values:
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0.
  - busy=0, done=0, word_count=0.
  - cpu_rst=BOOT_HOLD.
- start at cycle t: busy=1 and cpu_rst=1 from t+1; in_ready=1 from t+1 when len>0.
- Per word: at least 4 LOAD cycles plus 1 WRITE cycle. With in_valid held high, a word is written every 5 cycles.
- The 4th byte is accepted at cycle t; imem_we=1 during t+1, and the write commits at the rising edge that ends t+1.
- Final WRITE in cycle w: done=1 and cpu_rst=0 in w+1; IDLE in w+2.
- len=0: start at t gives DONE at t+1, with no writes and word_count=0.
- rst asserted mid-load: at the next edge, return to IDLE with the reset values above.
  - cpu_rst goes to BOOT_HOLD and the partial word is discarded.
  - Words already written are not rolled back.
- start and rst asserted in the same cycle: rst wins.

## Test plan
- Reset then idle, BOOT_HOLD=1: outputs match the reset values and cpu_rst=1. Pulse start with length=0 → done=1 one cycle later, cpu_rst=0, no imem_we.
- length=2, bytes 93 00 50 00 13 01 A0 00 with in_valid held high → imem_we at addr 0 with data 00500093, then at addr 1 with data 00A00113. Each strobe lasts one cycle, then done=1, word_count=2, cpu_rst=0.
- Same stream with in_valid toggled on alternate cycles → identical writes and data. Bytes offered while in_ready=0 (WRITE cycles) are not consumed.
- length=100 with 64 words of pattern 0xC0DE0000+i → 64 writes at addresses 0..63 with the correct data, then done=1 and word_count=64.
- rst asserted after 6 bytes of a length=3 load → IDLE, busy=0, cpu_rst=1, word_count=0. A subsequent full load writes addr 0 with the new data.
- start pulsed during LOAD → ignored: len and address are unchanged and the load completes with the original count.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time program loader: assembles little-endian 32-bit words from a byte
// stream and writes them sequentially into instruction memory while holding the core in reset.
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            k_q, k_d;
  logic [31:0]           word_q, word_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         len_clamped_s;
  logic [CW-1:0]         count_inc_s;

  assign len_clamped_s = (length > MAX_LEN) ? MAX_LEN : length;
  assign count_inc_s   = count_q + CW'(1'b1);

  // Outputs are computed for the next state so every one of them leaves a flop.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    addr_d     = addr_q;
    k_d        = k_q;
    word_d     = word_q;
    in_ready_d = 1'b0;
    imem_we_d  = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          len_d   = len_clamped_s;
          k_d     = 2'd0;
          addr_d  = {ADDR_WIDTH{1'b0}};
          count_d = {CW{1'b0}};
          if (len_clamped_s == {CW{1'b0}}) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d    = S_LOAD;
            in_ready_d = 1'b1;
            busy_d     = 1'b1;
            cpu_rst_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        busy_d = 1'b1;
        if (in_valid) begin
          word_d[{k_q, 3'b000} +: 8] = in_byte;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d   = S_WRITE;
            imem_we_d = 1'b1;
            waddr_d   = addr_q;
            wdata_d   = {in_byte, word_q[23:0]};
          end else begin
            in_ready_d = 1'b1;
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1'b1);
        count_d = count_inc_s;
        k_d     = 2'd0;
        if (count_inc_s == len_q) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b0;
        end else begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
      k_q        <= 2'd0;
      word_q     <= 32'd0;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      waddr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= 32'd0;
      cpu_rst_q  <= BOOT_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      imem_we_q  <= imem_we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams checked against
// an expected write list derived from the word list and the clamped length.
module tb_imem_loader;
  localparam int AW = 6;
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] length;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  imem_loader #(.ADDR_WIDTH(AW), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // mode: 0 = in_valid held high, 1 = alternate cycles, 2 = random
  task automatic run_load(input string name, input int len_in, input logic [31:0] words[$],
                          input int mode, input int inj_iter);
    int exp_len;
    logic [7:0] bytes[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0] got_data[$];
    int got_cyc[$];
    int idx = 0;
    int budget;
    bit seen_done = 0;
    bit prev_we = 0;
    bit v = 0;
    exp_len = (len_in > DEPTH) ? DEPTH : len_in;
    budget = exp_len * 20 + 50;
    for (int i = 0; i < words.size(); i++)
      for (int b = 0; b < 4; b++) bytes.push_back(words[i][8*b +: 8]);

    @(negedge clk);
    start = 1'b1; length = CW'(len_in); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({busy, cpu_rst, in_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL %s start_resp busy/cpu_rst/in_ready=%b expected 111", name, {busy, cpu_rst, in_ready});
    end

    for (int it = 0; it < budget; it++) begin
      if (imem_we) begin
        got_addr.push_back(imem_waddr);
        got_data.push_back(imem_wdata);
        got_cyc.push_back(cyc);
        n_vec++;
        if (prev_we) begin
          n_err++;
          $display("FAIL %s strobe_len imem_we high on consecutive cycles, expected single cycle", name);
        end
      end
      prev_we = imem_we;
      if (done) begin
        seen_done = 1;
        break;
      end
      case (mode)
        0: in_valid = 1'b1;
        1: begin v = ~v; in_valid = v; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_byte = (idx < bytes.size()) ? bytes[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
      if (it == inj_iter) begin
        start = 1'b1; length = CW'($urandom_range(1, 2 * DEPTH));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;

    n_vec++;
    if (!seen_done) begin
      n_err++;
      $display("FAIL %s timeout done not seen within %0d cycles", name, budget);
    end
    n_vec++;
    if (got_addr.size() != exp_len) begin
      n_err++;
      $display("FAIL %s write_count got %0d expected %0d", name, got_addr.size(), exp_len);
    end
    for (int i = 0; i < got_addr.size() && i < exp_len; i++) begin
      n_vec++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== words[i]) begin
        n_err++;
        $display("FAIL %s write[%0d] got addr=%0d data=%h expected addr=%0d data=%h",
                 name, i, got_addr[i], got_data[i], i, words[i]);
      end
      if (mode == 0 && i > 0) begin
        n_vec++;
        if (got_cyc[i] - got_cyc[i-1] != 5) begin
          n_err++;
          $display("FAIL %s spacing[%0d] got %0d cycles expected 5", name, i, got_cyc[i] - got_cyc[i-1]);
        end
      end
    end
    if (seen_done) begin
      n_vec++;
      if (word_count !== CW'(exp_len) || cpu_rst !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
        n_err++;
        $display("FAIL %s done_state word_count=%0d cpu_rst=%b busy=%b in_ready=%b we=%b expected %0d 0 0 0 0",
                 name, word_count, cpu_rst, busy, in_ready, imem_we, exp_len);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || cpu_rst !== 1'b0 || busy !== 1'b0 || imem_waddr !== AW'(exp_len - 1) ||
        imem_wdata !== words[exp_len-1]) begin
      n_err++;
      $display("FAIL %s idle_after done=%b cpu_rst=%b busy=%b waddr=%0d wdata=%h expected 0 0 0 %0d %h",
               name, done, cpu_rst, busy, imem_waddr, imem_wdata, exp_len - 1, words[exp_len-1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; length = '0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({in_ready, imem_we, imem_waddr, imem_wdata, busy, done, word_count, cpu_rst} !==
        {1'b0, 1'b0, {AW{1'b0}}, 32'd0, 1'b0, 1'b0, {CW{1'b0}}, 1'b1}) begin
      n_err++;
      $display("FAIL reset_vals rdy=%b we=%b wa=%0d wd=%h busy=%b done=%b wc=%0d cpu_rst=%b expected all 0, cpu_rst=1",
               in_ready, imem_we, imem_waddr, imem_wdata, busy, done, word_count, cpu_rst);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; length = '0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({done, cpu_rst, busy, imem_we, in_ready} !== 5'b10000 || word_count !== '0) begin
      n_err++;
      $display("FAIL len0_done done/cpu_rst/busy/we/rdy=%b wc=%0d expected 10000 wc=0",
               {done, cpu_rst, busy, imem_we, in_ready}, word_count);
    end
    @(negedge clk);
    n_vec++;
    if ({done, cpu_rst, imem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL len0_idle done/cpu_rst/we=%b expected 000", {done, cpu_rst, imem_we});
    end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    w = '{32'h00500093, 32'h00A00113};
    run_load("basic", 2, w, 0, -1);
  endtask

  task automatic test_toggle();
    logic [31:0] w[$];
    w = '{32'h00500093, 32'h00A00113};
    run_load("toggle", 2, w, 1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic [31:0] w[$];
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_load("random", n, w, 2, -1);
    end
  endtask

  task automatic test_full();
    logic [31:0] w[$];
    for (int i = 0; i < DEPTH; i++) w.push_back(32'hC0DE0000 + 32'(i));
    run_load("full_clamp", 100, w, 0, -1);
  endtask

  task automatic test_mid_reset();
    logic [31:0] w[$];
    int cnt = 0;
    @(negedge clk);
    start = 1'b1; length = CW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 40 && cnt < 6; it++) begin
      in_valid = 1'b1; in_byte = 8'($urandom);
      if (in_ready) cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, cpu_rst, in_ready, imem_we, done} !== 5'b01000 || word_count !== '0 || imem_waddr !== '0) begin
      n_err++;
      $display("FAIL mid_reset busy/cpu_rst/rdy/we/done=%b wc=%0d wa=%0d expected 01000 wc=0 wa=0",
               {busy, cpu_rst, in_ready, imem_we, done}, word_count, imem_waddr);
    end
    w = '{$urandom, $urandom};
    run_load("after_reset", 2, w, 0, -1);
  endtask

  task automatic test_start_during_load();
    logic [31:0] w[$];
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    run_load("start_in_load", 5, w, 0, 7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_random();
    test_full();
    test_mid_reset();
    test_start_during_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
